iiitb_rv32i_wb_tracer: RTL and testbench
========================================

Name: iiitb_rv32i_wb_tracer

Overview:
Retirement-trace sink attached to the iiitb_rv32i core outputs NPC and WB_OUT. Samples an {NPC, WB_OUT} record whenever NPC changes and buffers records in a FIFO. Drains each record as two 32-bit words over a valid/ready stream to a logger or debug UART bridge. Drops records on overflow, with a sticky flag and a saturating drop counter.

Parameters:
DEPTH, 8, FIFO depth in records; power of 2, minimum 2; AW = log2(DEPTH) derived internally.

Ports:
clk  input  1  system clock; all state updates on rising edge
RN  input  1  asynchronous active-low reset
en  input  1  capture enable
npc_in  input  32  core NPC output
wb_in  input  32  core WB_OUT output
tr_data  output  32  stream word
tr_first  output  1  1 = NPC word (record start); 0 = WB word
tr_valid  output  1  stream word valid
tr_ready  input  1  downstream ready
level  output  AW+1  FIFO occupancy in records; excludes the output holding register
ovf  output  1  sticky overflow flag
drop_cnt  output  16  dropped-record count; saturates at 16'hFFFF
clr_ovf  input  1  synchronous clear of ovf and drop_cnt

Behaviour:
- Reset (RN=0, asynchronous):
  - FIFO empty; state IDLE; primed=0; last_npc=0.
  - tr_data=0, tr_first=0, tr_valid=0, level=0, ovf=0, drop_cnt=0.
- Capture: push request = en && (!primed || npc_in != last_npc).
- On every cycle with en=1: last_npc <= npc_in and primed <= 1. When en=0, last_npc and primed hold.
- Push accepted only when the registered count < DEPTH.
  - A push arriving while full is dropped, even if a pop occurs in the same cycle.
  - On a drop: ovf <= 1; drop_cnt increments, saturating at FFFF.
- clr_ovf=1: ovf <= 0 and drop_cnt <= 0. If a drop occurs in the same cycle, the drop wins: ovf=1, drop_cnt=1.
- Output FSM, states IDLE / SEND_PC / SEND_WB:
  - IDLE: if FIFO non-empty, pop the head into the holding register and go to SEND_PC.
  - SEND_PC: tr_valid=1, tr_first=1, tr_data=record.npc. On tr_ready, go to SEND_WB.
  - SEND_WB: tr_valid=1, tr_first=0, tr_data=record.wb. On tr_ready:
    - FIFO non-empty: pop the next record, go to SEND_PC (back-to-back, no bubble).
    - otherwise: go to IDLE, tr_valid=0.
- Stream rules:
  - tr_data and tr_first are stable while tr_valid && !tr_ready.
  - tr_valid never drops without a handshake.
- Latency: inputs presented in cycle 0 -> tr_valid=1 with the NPC word in cycle 2 when the FIFO was empty and the FSM was IDLE.
- Simultaneous push and pop on a non-full FIFO: both take effect; level unchanged.
- Pointers wrap modulo DEPTH; count is AW+1 bits.
- Reset mid-record aborts the stream word immediately (tr_valid=0); the partial record is lost.
- Throughput: one record per 2 cycles at most. Sustained NPC change every cycle with tr_ready=1 fills the FIFO; this is expected.

Decomposition:
- Package iiitb_rv32i_pkg:
  - XLEN=32
  - trace record typedef {npc[31:0], wb[31:0]}
  - FSM state enum {IDLE, SEND_PC, SEND_WB}
  - DROP_CNT_W=16
- Sub-module iiitb_trace_fifo: synchronous FIFO; async active-low reset; push/pop/full/empty/count; DEPTH parameter.
- Top contains capture logic, overflow counters and the output FSM.

Test Plan:
- Reset release, en=1, npc_in 0x0, then 0x4, 0x8 on consecutive cycles, wb_in 0x11/0x22/0x33, tr_ready=1 -> stream 0x0(first=1), 0x11, 0x4(first=1), 0x22, 0x8(first=1), 0x33; first tr_valid in cycle 2.
- npc_in held at 0x10 for 5 cycles with en=1 -> exactly one record pushed; level peaks at 1.
- tr_ready=0, 12 distinct NPCs, DEPTH=8 -> level=8, one record in holding register, 3 dropped, ovf=1, drop_cnt=3; tr_data held at the first NPC.
- From the prior state: pulse clr_ovf in the same cycle as a new drop -> ovf=1, drop_cnt=1. Pulse again with no drop -> ovf=0, drop_cnt=0.
- Random tr_ready toggling during SEND_PC/SEND_WB -> tr_data/tr_first stable while stalled; word order preserved; no records lost below full.
- Assert RN low during SEND_WB -> tr_valid=0 and level=0 asynchronously; after release the first new record streams normally.

Source files
------------

// File: rtl/iiitb_rv32i_pkg.sv
// Shared types for the iiitb_rv32i retirement-trace sink: record layout,
// output FSM states and counter widths.
package iiitb_rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int DROP_CNT_W = 16;

  typedef struct packed {
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] wb;
  } trace_rec_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_PC = 2'd1,
    SEND_WB = 2'd2
  } tr_state_e;

endpackage

// File: rtl/iiitb_trace_fifo.sv
// Synchronous record FIFO with a head-of-queue read port; pushes while full
// and pops while empty are ignored.
module iiitb_trace_fifo
  import iiitb_rv32i_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  trace_rec_t             i_din,
  input  logic                   i_pop,
  output trace_rec_t             o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  trace_rec_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW + 1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage carries no reset; only entries behind the write pointer are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/iiitb_rv32i_wb_tracer.sv
// Retirement-trace sink: captures {NPC, WB_OUT} on every NPC change, queues the
// records and streams each as an NPC word followed by a WB word.
module iiitb_rv32i_wb_tracer
  import iiitb_rv32i_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   RN,
  input  logic                   en,
  input  logic [XLEN-1:0]        npc_in,
  input  logic [XLEN-1:0]        wb_in,
  output logic [XLEN-1:0]        tr_data,
  output logic                   tr_first,
  output logic                   tr_valid,
  input  logic                   tr_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  output logic [DROP_CNT_W-1:0]  drop_cnt,
  input  logic                   clr_ovf
);

  tr_state_e             r_state;
  tr_state_e             w_state_next;
  trace_rec_t            r_hold;
  trace_rec_t            w_head;
  trace_rec_t            w_rec_in;
  logic                  r_primed;
  logic [XLEN-1:0]       r_last_npc;
  logic                  r_ovf;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic                  w_push_req;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop;
  logic                  w_pop;

  // The very first enabled sample is always recorded, even if NPC equals the reset value.
  assign w_push_req = en && (!r_primed || (npc_in != r_last_npc));
  assign w_drop     = w_push_req && w_full;
  assign w_rec_in   = {npc_in, wb_in};
  assign ovf        = r_ovf;
  assign drop_cnt   = r_drop_cnt;

  iiitb_trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (RN),
    .i_push  (w_push_req),
    .i_din   (w_rec_in),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (level)
  );

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      r_primed   <= 1'b0;
      r_last_npc <= '0;
    end else if (en) begin
      r_primed   <= 1'b1;
      r_last_npc <= npc_in;
    end
  end

  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (clr_ovf)                 r_drop_cnt <= DROP_CNT_W'(1);
      else if (r_drop_cnt != '1)   r_drop_cnt <= r_drop_cnt + 1'b1;
    end else if (clr_ovf) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      r_state <= IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) r_hold <= w_head;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = SEND_PC;
        end
      end
      SEND_PC: begin
        if (tr_ready) w_state_next = SEND_WB;
      end
      SEND_WB: begin
        if (tr_ready) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = SEND_PC;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    tr_valid = 1'b0;
    tr_first = 1'b0;
    tr_data  = '0;
    case (r_state)
      SEND_PC: begin
        tr_valid = 1'b1;
        tr_first = 1'b1;
        tr_data  = r_hold.npc;
      end
      SEND_WB: begin
        tr_valid = 1'b1;
        tr_data  = r_hold.wb;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iiitb_rv32i_wb_tracer.sv
// Self-checking bench for the trace sink: directed scenarios plus a randomized
// stall run scored against a word-level queue model.
module tb_iiitb_rv32i_wb_tracer;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        RN;
  logic        en;
  logic [31:0] npc_in;
  logic [31:0] wb_in;
  logic [31:0] tr_data;
  logic        tr_first;
  logic        tr_valid;
  logic        tr_ready;
  logic [AW:0] level;
  logic        ovf;
  logic [15:0] drop_cnt;
  logic        clr_ovf;

  int n_vec = 0;
  int n_err = 0;

  // Capture model state: what the sink should remember about the last enabled NPC.
  logic        m_primed;
  logic [31:0] m_last;
  logic [32:0] exp_q[$];
  logic [31:0] ov_npc [12];
  logic [31:0] ov_wb  [12];

  always #5 clk = ~clk;

  iiitb_rv32i_wb_tracer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .RN       (RN),
    .en       (en),
    .npc_in   (npc_in),
    .wb_in    (wb_in),
    .tr_data  (tr_data),
    .tr_first (tr_first),
    .tr_valid (tr_valid),
    .tr_ready (tr_ready),
    .level    (level),
    .ovf      (ovf),
    .drop_cnt (drop_cnt),
    .clr_ovf  (clr_ovf)
  );

  // Advance one clock; inputs are re-driven 1 time unit after the edge.
  task automatic step();
    if (en) begin
      m_last   = npc_in;
      m_primed = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done = 1'b0;
    en       = 1'b0;
    tr_ready = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (!tr_valid && level == 0) done = 1'b1;
      step();
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL drain_timeout: valid=%0d level=%0d, required idle and empty", tr_valid, level);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_vec++; if (tr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0d want 0", tr_valid); end
    n_vec++; if (tr_first !== 1'b0) begin n_err++; $display("FAIL rst_first: got %0d want 0", tr_first); end
    n_vec++; if (tr_data !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", tr_data); end
    n_vec++; if (level !== '0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %0d want 0", ovf); end
    n_vec++; if (drop_cnt !== 16'h0) begin n_err++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
    @(posedge clk);
    #1;
    RN = 1'b1;
  endtask

  task automatic test_basic();
    logic [32:0] got[$];
    logic [32:0] want [6];
    logic [31:0] wbs [3];
    int          first_cyc = -1;
    wbs  = '{32'h11, 32'h22, 32'h33};
    want = '{{1'b1, 32'h0}, {1'b0, 32'h11}, {1'b1, 32'h4},
             {1'b0, 32'h22}, {1'b1, 32'h8}, {1'b0, 32'h33}};
    for (int c = 0; c < 14; c++) begin
      en       = (c < 3);
      tr_ready = 1'b1;
      if (c < 3) begin
        npc_in = 32'(c * 4);
        wb_in  = wbs[c];
      end
      @(negedge clk);
      if (tr_valid && first_cyc < 0) first_cyc = c;
      if (tr_valid && tr_ready) got.push_back({tr_first, tr_data});
      step();
    end
    n_vec++;
    if (first_cyc != 2) begin n_err++; $display("FAIL basic_latency: first valid cycle %0d want 2", first_cyc); end
    n_vec++;
    if (got.size() != 6) begin n_err++; $display("FAIL basic_count: got %0d words want 6", got.size()); end
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (i >= got.size() || got[i] !== want[i]) begin
        n_err++;
        $display("FAIL basic_word%0d: got %h want %h", i, (i < got.size()) ? got[i] : 33'h0, want[i]);
      end
    end
  endtask

  task automatic test_hold();
    int          peak = 0;
    int          recs = 0;
    logic [31:0] first_word = 32'h0;
    for (int c = 0; c < 14; c++) begin
      en       = (c < 5);
      npc_in   = 32'h10;
      wb_in    = 32'h55;
      tr_ready = (c >= 8);
      @(negedge clk);
      if (int'(level) > peak) peak = int'(level);
      if (tr_valid && tr_ready && tr_first) begin
        recs++;
        first_word = tr_data;
      end
      step();
    end
    n_vec++; if (peak != 1) begin n_err++; $display("FAIL hold_peak_level: got %0d want 1", peak); end
    n_vec++; if (recs != 1) begin n_err++; $display("FAIL hold_records: got %0d want 1", recs); end
    n_vec++; if (first_word !== 32'h10) begin n_err++; $display("FAIL hold_npc: got %h want 00000010", first_word); end
  endtask

  task automatic test_overflow();
    tr_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      en        = 1'b1;
      npc_in    = 32'h100 + 32'(i * 4);
      wb_in     = $urandom;
      ov_npc[i] = npc_in;
      ov_wb[i]  = wb_in;
      step();
    end
    en = 1'b0;
    step();
    step();
    @(negedge clk);
    n_vec++; if (level !== 4'(DEPTH)) begin n_err++; $display("FAIL ovf_level: got %0d want %0d", level, DEPTH); end
    n_vec++; if (tr_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %0d want 1", tr_valid); end
    n_vec++; if (tr_first !== 1'b1) begin n_err++; $display("FAIL ovf_first: got %0d want 1", tr_first); end
    n_vec++; if (tr_data !== 32'h100) begin n_err++; $display("FAIL ovf_data: got %h want 00000100", tr_data); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0d want 1", ovf); end
    n_vec++; if (drop_cnt !== 16'd3) begin n_err++; $display("FAIL ovf_drop_cnt: got %0d want 3", drop_cnt); end
    step();
  endtask

  task automatic test_clr_ovf();
    logic [32:0] got[$];
    int          first_hs = -1;
    int          last_hs  = -1;
    en      = 1'b1;
    npc_in  = 32'h200;
    wb_in   = 32'h0;
    clr_ovf = 1'b1;
    step();
    en      = 1'b0;
    clr_ovf = 1'b0;
    @(negedge clk);
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL clr_drop_ovf: got %0d want 1", ovf); end
    n_vec++; if (drop_cnt !== 16'd1) begin n_err++; $display("FAIL clr_drop_cnt: got %0d want 1", drop_cnt); end
    n_vec++; if (level !== 4'(DEPTH)) begin n_err++; $display("FAIL clr_level: got %0d want %0d", level, DEPTH); end
    step();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    @(negedge clk);
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL clr_ovf: got %0d want 0", ovf); end
    n_vec++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL clr_cnt: got %0d want 0", drop_cnt); end
    step();
    // Drain the nine surviving records; they must come out in order with no bubbles.
    tr_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tr_valid && tr_ready) begin
        got.push_back({tr_first, tr_data});
        if (first_hs < 0) first_hs = c;
        last_hs = c;
      end
      step();
    end
    n_vec++;
    if (got.size() != 18) begin n_err++; $display("FAIL ovf_drain_count: got %0d words want 18", got.size()); end
    n_vec++;
    if (last_hs - first_hs != 17) begin n_err++; $display("FAIL back_to_back: span %0d cycles want 17", last_hs - first_hs); end
    for (int r = 0; r < 9; r++) begin
      n_vec++;
      if (2 * r + 1 >= got.size() || got[2*r] !== {1'b1, ov_npc[r]} || got[2*r+1] !== {1'b0, ov_wb[r]}) begin
        n_err++;
        $display("FAIL ovf_drain_rec%0d: got %h/%h want %h/%h", r,
                 (2 * r + 1 < got.size()) ? got[2*r] : 33'h0,
                 (2 * r + 1 < got.size()) ? got[2*r+1] : 33'h0,
                 {1'b1, ov_npc[r]}, {1'b0, ov_wb[r]});
      end
    end
  endtask

  task automatic test_random_stall();
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = 32'h0;
    logic        prev_first = 1'b0;
    logic [32:0] w;
    bit          done = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 460 && !done; c++) begin
      if (c < 400) begin
        en       = ($urandom_range(0, 3) == 0) && (((exp_q.size() + 1) / 2) < 6);
        npc_in   = ($urandom_range(0, 3) == 0) ? m_last : $urandom;
        wb_in    = $urandom;
        tr_ready = ($urandom_range(0, 3) != 0);
      end else begin
        en       = 1'b0;
        tr_ready = ($urandom_range(0, 1) != 0);
      end
      @(negedge clk);
      if (prev_stall) begin
        n_vec++;
        if (tr_valid !== 1'b1 || tr_data !== prev_data || tr_first !== prev_first) begin
          n_err++;
          $display("FAIL stall_hold c%0d: got v=%0d f=%0d d=%h want v=1 f=%0d d=%h",
                   c, tr_valid, tr_first, tr_data, prev_first, prev_data);
        end
      end
      if (tr_valid && tr_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rand_extra c%0d: got f=%0d d=%h want no word", c, tr_first, tr_data);
        end else begin
          w = exp_q.pop_front();
          if ({tr_first, tr_data} !== w) begin
            n_err++;
            $display("FAIL rand_order c%0d: got f=%0d d=%h want f=%0d d=%h", c, tr_first, tr_data, w[32], w[31:0]);
          end
        end
      end
      prev_stall = tr_valid && !tr_ready;
      prev_data  = tr_data;
      prev_first = tr_first;
      if (en && (!m_primed || npc_in != m_last)) begin
        exp_q.push_back({1'b1, npc_in});
        exp_q.push_back({1'b0, wb_in});
      end
      if (c >= 400 && exp_q.size() == 0 && !tr_valid) done = 1'b1;
      step();
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_lost: %0d words missing want 0", exp_q.size()); end
    n_vec++; if (drop_cnt !== 16'h0) begin n_err++; $display("FAIL rand_drops: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_reset_mid();
    tr_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      en       = (c < 3);
      npc_in   = 32'h300 + 32'(c * 4);
      wb_in    = 32'h301 + 32'(c * 4);
      tr_ready = (c == 2);
      if (c == 3) begin
        @(negedge clk);
        n_vec++;
        if (tr_valid !== 1'b1 || tr_first !== 1'b0 || tr_data !== 32'h301) begin
          n_err++;
          $display("FAIL mid_send_wb: got v=%0d f=%0d d=%h want v=1 f=0 d=00000301", tr_valid, tr_first, tr_data);
        end
      end
      step();
    end
    #2;
    RN = 1'b0;
    #1;
    n_vec++; if (tr_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %0d want 0", tr_valid); end
    n_vec++; if (level !== '0) begin n_err++; $display("FAIL mid_rst_level: got %0d want 0", level); end
    @(posedge clk);
    #1;
    RN       = 1'b1;
    m_primed = 1'b0;
    m_last   = 32'h0;
    tr_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      en     = (c == 0);
      npc_in = 32'h40;
      wb_in  = 32'h44;
      @(negedge clk);
      if (c == 1) begin
        n_vec++; if (tr_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_c1: got v=%0d want 0", tr_valid); end
      end
      if (c == 2) begin
        n_vec++;
        if (tr_valid !== 1'b1 || tr_first !== 1'b1 || tr_data !== 32'h40) begin
          n_err++;
          $display("FAIL post_rst_npc: got v=%0d f=%0d d=%h want v=1 f=1 d=00000040", tr_valid, tr_first, tr_data);
        end
      end
      if (c == 3) begin
        n_vec++;
        if (tr_valid !== 1'b1 || tr_first !== 1'b0 || tr_data !== 32'h44) begin
          n_err++;
          $display("FAIL post_rst_wb: got v=%0d f=%0d d=%h want v=1 f=0 d=00000044", tr_valid, tr_first, tr_data);
        end
      end
      if (c == 4) begin
        n_vec++; if (tr_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_idle: got v=%0d want 0", tr_valid); end
      end
      step();
    end
  endtask

  initial begin
    RN       = 1'b0;
    en       = 1'b0;
    npc_in   = 32'h0;
    wb_in    = 32'h0;
    tr_ready = 1'b0;
    clr_ovf  = 1'b0;
    m_primed = 1'b0;
    m_last   = 32'h0;
    test_reset();
    test_basic();
    drain();
    test_hold();
    drain();
    test_overflow();
    test_clr_ovf();
    drain();
    test_random_stall();
    drain();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
